// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the MTM ALU serial front end (deserializer and serializer).
package mtm_alu_pkg;

    localparam int unsigned N_DATA  = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = 11;

    localparam logic [7:0] CTL_IDLE = 8'hFF;
    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_OP   = 8'h93;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TYPE = 2'd1,
        ST_DATA = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // One serial step of CRC x^4+x+1, MSB first.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic din);
        logic fb;
        fb = crc[3] ^ din;
        return {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    // Opcodes the ALU core implements.
    function automatic logic op_valid(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// Serial input line and parallel request bus towards the ALU core.
interface mtm_alu_deserializer_if;
    logic        sin;
    logic [31:0] A;
    logic [31:0] B;
    logic [7:0]  CTL;
    logic        out_valid;

    modport master (input sin, output A, B, CTL, out_valid);
    modport slave  (output sin, input A, B, CTL, out_valid);
endinterface

// File: rtl/mtm_alu_crc4.sv
// Serial CRC4 accumulator with synchronous clear and bit enable.
module mtm_alu_crc4
    import mtm_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc
);

    // Clear wins over a shift in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      crc <= 4'h0;
        else if (clr) crc <= 4'h0;
        else if (en)  crc <= crc4_step(crc, din);
    end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// Assembles 8 data frames + 1 command frame from the serial line and presents
// one checked request (or error code) to the ALU core for a single cycle.
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    mtm_alu_deserializer_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DATA);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_DATA + 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       bit_cnt;
    logic             is_cmd;
    logic [7:0]       byte_sr;
    logic [63:0]      shift_sr;
    logic [CNT_W-1:0] frame_cnt;
    logic             frame_err;
    logic [3:0]       crc;
    logic             crc_en_c;
    logic             crc_bit_c;
    logic             crc_clr_c;
    logic             data_end_c;
    logic             cmd_end_c;

    // Frame state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-bit strobes. In a cmd frame the d7 slot carries the
    // constant 1 marker into the CRC, followed by the three opcode bits.
    always_comb begin
        state_nxt  = state;
        crc_en_c   = 1'b0;
        crc_bit_c  = bus.sin;
        crc_clr_c  = 1'b0;
        data_end_c = 1'b0;
        cmd_end_c  = 1'b0;
        case (state)
            ST_IDLE: if (!bus.sin) state_nxt = ST_TYPE;
            ST_TYPE: state_nxt = ST_DATA;
            ST_DATA: begin
                if (is_cmd) begin
                    crc_en_c = (bit_cnt < 3'd4);
                    if (bit_cnt == 3'd0) crc_bit_c = 1'b1;
                end else begin
                    crc_en_c = 1'b1;
                end
                if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                state_nxt  = ST_IDLE;
                data_end_c = !is_cmd;
                cmd_end_c  = is_cmd;
                crc_clr_c  = is_cmd;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mtm_alu_crc4 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr_c),
        .en  (crc_en_c),
        .din (crc_bit_c),
        .crc (crc)
    );

    // Frame assembly: byte capture, packet shift register, count and sticky framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            is_cmd    <= 1'b0;
            byte_sr   <= 8'h00;
            shift_sr  <= 64'h0;
            frame_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_TYPE) begin
                is_cmd  <= (bus.sin == FRAME_CMD);
                bit_cnt <= 3'd0;
            end
            if (state == ST_DATA) begin
                byte_sr <= {byte_sr[6:0], bus.sin};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (data_end_c) begin
                if (bus.sin) begin
                    shift_sr <= {shift_sr[55:0], byte_sr};
                    if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
                end else begin
                    frame_err <= 1'b1;
                end
            end
            if (cmd_end_c) begin
                shift_sr  <= 64'h0;
                frame_cnt <= '0;
                frame_err <= 1'b0;
            end
        end
    end

    // Request output: one-cycle CTL/out_valid pulse; A/B hold until the next packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.A         <= 32'h0;
            bus.B         <= 32'h0;
            bus.CTL       <= CTL_IDLE;
            bus.out_valid <= 1'b0;
        end else begin
            bus.CTL       <= CTL_IDLE;
            bus.out_valid <= 1'b0;
            if (cmd_end_c) begin
                bus.out_valid <= 1'b1;
                bus.A         <= 32'h0;
                bus.B         <= 32'h0;
                if (!bus.sin || frame_err || frame_cnt != CNT_FULL) begin
                    bus.CTL <= ERR_DATA;
                end else if (crc != byte_sr[3:0]) begin
                    bus.CTL <= ERR_CRC;
                end else if (!op_valid(byte_sr[6:4])) begin
                    bus.CTL <= ERR_OP;
                end else begin
                    bus.CTL <= {1'b0, byte_sr[6:0]};
                    bus.A   <= shift_sr[31:0];
                    bus.B   <= shift_sr[63:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized bench for mtm_alu_deserializer with a packet-level reference model.
module tb_mtm_alu_deserializer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mtm_alu_deserializer_if bus();

    mtm_alu_deserializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    typedef struct {
        string       name;
        int          cyc;
        logic        v;
        logic [7:0]  ctl;
        logic        ab;
        logic [31:0] a;
        logic [31:0] b;
    } lit_t;

    exp_t        exp_q[$];
    lit_t        lit_q[$];
    logic [7:0]  m_bytes[$];
    logic        m_ferr = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] held_a = 32'h0;
    logic [31:0] held_b = 32'h0;
    logic        e_v;
    logic [7:0]  e_ctl;
    logic [31:0] e_a;
    logic [31:0] e_b;

    always @(posedge clk) cyc <= cyc + 1;

    // CRC x^4+x+1 over the 68-bit message {B,A,1,OP}, computed bit by bit.
    function automatic logic [3:0] model_crc(input logic [63:0] ba, input logic [2:0] op);
        logic [67:0] msg;
        logic [3:0]  c;
        msg = {ba, 1'b1, op};
        c = 4'h0;
        for (int i = 67; i >= 0; i--)
            c = {c[2:0], 1'b0} ^ (((c[3] ^ msg[i]) == 1'b1) ? 4'h3 : 4'h0);
        return c;
    endfunction

    function automatic logic op_ok(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endtask

    // Single compare process: model every cycle, plus literal expectations.
    always @(negedge clk) begin
        if (rst) begin
            held_a = 32'h0;
            held_b = 32'h0;
        end
        e_v = 1'b0; e_ctl = 8'hFF; e_a = held_a; e_b = held_b;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e_v = 1'b1; e_ctl = exp_q[0].ctl; e_a = exp_q[0].a; e_b = exp_q[0].b;
            held_a = e_a; held_b = e_b;
            void'(exp_q.pop_front());
        end
        cmp("model_valid", 32'(bus.out_valid), 32'(e_v));
        cmp("model_ctl", 32'(bus.CTL), 32'(e_ctl));
        cmp("model_a", bus.A, e_a);
        cmp("model_b", bus.B, e_b);
        while (lit_q.size() > 0 && lit_q[0].cyc == cyc) begin
            cmp({lit_q[0].name, "_valid"}, 32'(bus.out_valid), 32'(lit_q[0].v));
            cmp({lit_q[0].name, "_ctl"}, 32'(bus.CTL), 32'(lit_q[0].ctl));
            if (lit_q[0].ab) begin
                cmp({lit_q[0].name, "_a"}, bus.A, lit_q[0].a);
                cmp({lit_q[0].name, "_b"}, bus.B, lit_q[0].b);
            end
            void'(lit_q.pop_front());
        end
        if (cyc == 2) begin
            cmp("pin_crc_and_zero", 32'(model_crc(64'h0, 3'b000)), 32'hB);
            cmp("pin_crc_add_zero", 32'(model_crc(64'h0, 3'b100)), 32'h7);
            cmp("pin_crc_op010_zero", 32'(model_crc(64'h0, 3'b010)), 32'hD);
        end
    end

    task automatic lit(input string name, input int k, input logic v, input logic [7:0] ctl,
                       input logic ab, input logic [31:0] a, input logic [31:0] b);
        lit_t e;
        e.name = name; e.cyc = k; e.v = v; e.ctl = ctl; e.ab = ab; e.a = a; e.b = b;
        lit_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1;
        bus.sin = b;
    endtask

    task automatic send_idle(input int n);
        repeat (n) send_bit(1'b1);
    endtask

    // Drive one frame and update the packet model when it completes.
    task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
        exp_t        e;
        logic [63:0] ba;
        logic [3:0]  c;
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
        if (!typ) begin
            if (stop) m_bytes.push_back(d);
            else      m_ferr = 1'b1;
        end else begin
            e.cyc = cyc + 1; e.a = 32'h0; e.b = 32'h0;
            if (!stop || m_ferr || m_bytes.size() != 8) begin
                e.ctl = 8'hC9;
            end else begin
                ba = 64'h0;
                foreach (m_bytes[i]) ba = {ba[55:0], m_bytes[i]};
                c = model_crc(ba, d[6:4]);
                if (c != d[3:0])        e.ctl = 8'hA5;
                else if (!op_ok(d[6:4])) e.ctl = 8'h93;
                else begin
                    e.ctl = {1'b0, d[6:0]};
                    e.a = ba[31:0];
                    e.b = ba[63:32];
                end
            end
            exp_q.push_back(e);
            m_bytes.delete();
            m_ferr = 1'b0;
        end
    endtask

    task automatic send_data(input logic [63:0] ba, input int nd);
        logic [7:0] byt;
        for (int i = 0; i < nd; i++) begin
            byt = (i < 8) ? ba[63 - 8*i -: 8] : 8'h5A;
            send_frame(1'b0, byt, 1'b1);
        end
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.sin = 1'b1;
        m_bytes.delete();
        m_ferr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] ba1, ba2, ba;
        logic [7:0]  cmd1, cmd2, cmd, byt;
        logic [2:0]  op;
        int          k1, kind, nd, bad_idx, pick;

        bus.sin = 1'b1;
        lit("reset", 1, 1'b0, 8'hFF, 1'b1, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_idle(2);

        // Zero operands, AND with correct CRC.
        send_data(64'h0, 8);
        send_frame(1'b1, 8'h0B, 1'b1);
        lit("t1_ok", cyc + 1, 1'b1, 8'h0B, 1'b1, 32'h0, 32'h0);
        lit("t1_after", cyc + 2, 1'b0, 8'hFF, 1'b0, 32'h0, 32'h0);
        send_idle(3);

        // ADD with CRC 7, exactly one cycle.
        send_data(64'h0, 8);
        send_frame(1'b1, 8'h47, 1'b1);
        lit("t2_ok", cyc + 1, 1'b1, 8'h47, 1'b1, 32'h0, 32'h0);
        lit("t2_after", cyc + 2, 1'b0, 8'hFF, 1'b0, 32'h0, 32'h0);
        send_idle(3);

        // Bad CRC.
        send_data(64'h0, 8);
        send_frame(1'b1, 8'h0C, 1'b1);
        lit("t3_crc", cyc + 1, 1'b1, 8'hA5, 1'b1, 32'h0, 32'h0);
        send_idle(3);

        // Valid CRC, unsupported opcode.
        send_data(64'h0, 8);
        send_frame(1'b1, 8'h2D, 1'b1);
        lit("t4_op", cyc + 1, 1'b1, 8'h93, 1'b1, 32'h0, 32'h0);
        send_idle(3);

        // Too few and too many data frames.
        send_data(64'h0, 7);
        send_frame(1'b1, 8'h0B, 1'b1);
        lit("t5_seven", cyc + 1, 1'b1, 8'hC9, 1'b1, 32'h0, 32'h0);
        send_idle(2);
        send_data(64'h0, 9);
        send_frame(1'b1, 8'h0B, 1'b1);
        lit("t5_nine", cyc + 1, 1'b1, 8'hC9, 1'b1, 32'h0, 32'h0);
        send_idle(2);

        // Reset mid-packet, then a clean packet.
        send_data(64'h0, 3);
        pulse_rst();
        send_idle(1);
        send_data(64'h0, 8);
        send_frame(1'b1, 8'h0B, 1'b1);
        lit("t6_ok", cyc + 1, 1'b1, 8'h0B, 1'b1, 32'h0, 32'h0);
        send_idle(3);

        // Back-to-back packets with no idle bits between frames.
        ba1 = 64'h0123456789ABCDEF;
        ba2 = 64'hFEDCBA9876543210;
        cmd1 = {1'b0, 3'b100, model_crc(ba1, 3'b100)};
        cmd2 = {1'b0, 3'b101, model_crc(ba2, 3'b101)};
        send_data(ba1, 8);
        send_frame(1'b1, cmd1, 1'b1);
        k1 = cyc;
        lit("b2b_first", k1 + 1, 1'b1, cmd1, 1'b1, ba1[31:0], ba1[63:32]);
        lit("b2b_second", k1 + 1 + 9 * 11, 1'b1, cmd2, 1'b1, ba2[31:0], ba2[63:32]);
        send_data(ba2, 8);
        send_frame(1'b1, cmd2, 1'b1);
        send_idle(4);

        // Random packets covering every error path.
        for (int p = 0; p < 40; p++) begin
            kind = int'($urandom_range(0, 9));
            ba = {$urandom, $urandom};
            nd = (kind == 1) ? 7 : (kind == 2) ? 9 : 8;
            bad_idx = (kind == 3) ? int'($urandom_range(0, 7)) : -1;
            for (int i = 0; i < nd; i++) begin
                byt = (i < 8) ? ba[63 - 8*i -: 8] : 8'h5A;
                send_frame(1'b0, byt, i != bad_idx);
                if ($urandom_range(0, 3) == 0) send_idle(1);
            end
            pick = int'($urandom_range(0, 3));
            op = (kind == 4) ? {pick[1], 1'b1, pick[0]} : {pick[1], 1'b0, pick[0]};
            cmd = {1'($urandom_range(0, 1)), op, model_crc(ba, op)};
            if (kind == 5) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
            send_frame(1'b1, cmd, kind != 6);
            send_idle((kind == 6) ? 2 : int'($urandom_range(0, 2)));
        end

        send_idle(6);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
